// File: rtl/pwm_audio_pkg.sv
// Shared types and helpers for the PWM audio sample path.
// Offset-binary conversion and midscale for an N-bit duty.
package pwm_audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREFILL,
    RUN
  } state_t;

  function automatic logic [31:0] midscale(input int n);
    return 32'd1 << (n - 1);
  endfunction

  // Keep the top n bits of an sw-bit sample and flip its sign bit.
  function automatic logic [31:0] to_duty(
    input logic [31:0] s,
    input int          sw,
    input int          n
  );
    logic [31:0] m;
    m = (32'd1 << n) - 32'd1;
    return ((s >> (sw - n)) & m) ^ midscale(n);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO with flush.
// Push when full and pop when empty are both ignored.
module sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o      = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign occupancy_o = cnt_q;
  assign rdata_o     = mem_q[rd_q];
  assign do_push     = push_i & ~full_o;
  assign do_pop      = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/pwm_sample_sequencer.sv
// Paces buffered audio samples into the PWM stage, one per frame.
// duty_val only moves on the frame-boundary edge.
module pwm_sample_sequencer
  import pwm_audio_pkg::*;
#(
  parameter int N          = 10,
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PREFILL    = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                s_ready,
  output logic [N-1:0]        duty_val,
  output logic                frame_tick,
  output logic                underrun,
  output logic [15:0]         underrun_cnt
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PRE_OCC = (AW+1)'(PREFILL);
  localparam logic [N-1:0] MID    = N'(midscale(N));

  logic [N-1:0]        period_q;
  state_t              state_q;
  state_t              state_d;
  logic [N-1:0]        duty_q;
  logic [N-1:0]        duty_d;
  logic [15:0]         ucnt_q;
  logic [SAMPLE_W-1:0] rdata;
  logic [AW:0]         occ;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                flush;
  logic                urun;
  logic                pre_ok;
  logic [N-1:0]        samp_duty;

  assign frame_tick   = &period_q;
  assign duty_val     = duty_q;
  assign underrun     = urun;
  assign underrun_cnt = ucnt_q;

  // IDLE keeps the buffer empty, so nothing is offered there.
  assign s_ready   = enable & ~full & (state_q != IDLE);
  assign push      = s_valid & s_ready;
  assign flush     = ~enable | (state_q == IDLE);
  assign pre_ok    = (occ >= PRE_OCC);
  assign samp_duty = N'(to_duty(32'(rdata), SAMPLE_W, N));

  sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (flush),
    .wdata_i     (s_data),
    .rdata_o     (rdata),
    .occupancy_o (occ),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    pop     = 1'b0;
    urun    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      if (frame_tick) duty_d = MID;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = pwm_audio_pkg::PREFILL;
          if (frame_tick) duty_d = MID;
        end
        pwm_audio_pkg::PREFILL: begin
          if (frame_tick) begin
            if (pre_ok) begin
              pop     = 1'b1;
              duty_d  = samp_duty;
              state_d = RUN;
            end else begin
              duty_d  = MID;
            end
          end
        end
        RUN: begin
          if (frame_tick) begin
            if (empty) begin
              duty_d  = MID;
              urun    = 1'b1;
              state_d = pwm_audio_pkg::PREFILL;
            end else begin
              pop     = 1'b1;
              duty_d  = samp_duty;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= '0;
      state_q  <= IDLE;
      duty_q   <= MID;
      ucnt_q   <= '0;
    end else begin
      period_q <= period_q + N'(1);
      state_q  <= state_d;
      duty_q   <= duty_d;
      if (urun && ucnt_q != 16'hFFFF)
        ucnt_q <= ucnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Directed bench for pwm_sample_sequencer with a duty scoreboard.
module tb_pwm_sample_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic [9:0]  duty_val;
  logic        frame_tick;
  logic        underrun;
  logic [15:0] underrun_cnt;

  int checks = 0;
  int errors = 0;
  int glitches = 0;

  logic [9:0]  exp_q[$];
  logic [9:0]  prev_duty;
  bit          prev_tick;

  logic [15:0] dtab[8] = '{16'h0000, 16'h2000, 16'hC000, 16'hFFC0,
                           16'h7FC0, 16'h8040, 16'h007F, 16'hF000};
  logic [9:0]  etab[8] = '{10'd512, 10'd640, 10'd256, 10'd511,
                           10'd1023, 10'd1, 10'd513, 10'd448};

  pwm_sample_sequencer #(
    .N(10), .SAMPLE_W(16), .FIFO_DEPTH(4), .PREFILL(2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .duty_val     (duty_val),
    .frame_tick   (frame_tick),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  // duty may only move on the edge right after a frame_tick
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_duty = duty_val;
      prev_tick = 1'b0;
    end else begin
      if (duty_val !== prev_duty && !prev_tick) glitches++;
      prev_duty = duty_val;
      prev_tick = frame_tick;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (frame_tick !== 1'b1 && n < 2100) begin
      step();
      n++;
    end
    chk({tag, "_tick_seen"}, 32'(frame_tick), 1);
  endtask

  task automatic pop_chk(input string tag);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_duty"}, 32'(duty_val), 32'(e));
    end
  endtask

  task automatic tick_pop(input string tag);
    wait_tick(tag);
    chk({tag, "_urun"}, 32'(underrun), 0);
    step();
    pop_chk(tag);
  endtask

  task automatic push(input logic [15:0] d, input logic [9:0] e);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (s_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("push_ready", 32'(s_ready), 1);
    if (s_ready === 1'b1) exp_q.push_back(e);
    step();
    s_valid = 1'b0;
  endtask

  task automatic fill_from(input int base, output int acc);
    int idx = 0;
    for (int c = 0; c < 8; c++) begin
      s_valid = 1'b1;
      s_data  = (idx < 4) ? dtab[base + idx] : 16'h1234;
      if (s_ready === 1'b1) begin
        if (idx < 4) exp_q.push_back(etab[base + idx]);
        idx++;
      end
      step();
    end
    acc = idx;
  endtask

  initial begin
    int first, nt, last, badgap, badd, badr, acc, n;
    first = -1; nt = 0; last = -1;
    badgap = 0; badd = 0; badr = 0;

    repeat (3) step();
    chk("rst_duty", 32'(duty_val), 512);
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    chk("rst_urun", 32'(underrun), 0);
    chk("rst_ucnt", 32'(underrun_cnt), 0);
    reset_n = 1'b1;

    for (int k = 1; k <= 3000; k++) begin
      step();
      if (duty_val !== 10'd512) badd++;
      if (s_ready !== 1'b0) badr++;
      if (frame_tick === 1'b1) begin
        if (first < 0) first = k;
        else if (k - last != 1024) badgap++;
        last = k;
        nt++;
      end
    end
    chk("idle_first_tick", 32'(first), 1023);
    chk("idle_tick_count", 32'(nt), 2);
    chk("idle_tick_gap", 32'(badgap), 0);
    chk("idle_duty", 32'(badd), 0);
    chk("idle_ready", 32'(badr), 0);

    enable = 1'b1;
    push(16'h8000, 10'd0);
    push(16'h7FFF, 10'd1023);
    tick_pop("p_min");
    tick_pop("p_max");

    wait_tick("ur");
    chk("ur_pulse", 32'(underrun), 1);
    step();
    chk("ur_duty", 32'(duty_val), 512);
    chk("ur_pulse_end", 32'(underrun), 0);
    chk("ur_cnt", 32'(underrun_cnt), 1);

    push(16'h4000, 10'd768);
    push(16'h4000, 10'd768);
    tick_pop("pre_a");
    tick_pop("pre_b");

    fill_from(0, acc);
    chk("fill_acc", 32'(acc), 4);
    chk("fill_ready", 32'(s_ready), 0);
    wait_tick("full");
    chk("full_tick_ready", 32'(s_ready), 0);
    step();
    s_valid = 1'b0;
    pop_chk("full_pop");
    chk("full_ready_after", 32'(s_ready), 1);
    tick_pop("run_b");

    repeat (300) step();
    enable = 1'b0;
    step();
    chk("dis_ready", 32'(s_ready), 0);
    chk("dis_duty_hold", 32'(duty_val), 640);
    exp_q.delete();
    wait_tick("dis");
    chk("dis_duty_tick", 32'(duty_val), 640);
    chk("dis_urun", 32'(underrun), 0);
    step();
    chk("dis_duty_mid", 32'(duty_val), 512);

    enable = 1'b1;
    fill_from(4, acc);
    s_valid = 1'b0;
    chk("flushed_acc", 32'(acc), 4);
    tick_pop("refill");

    repeat (500) step();
    reset_n = 1'b0;
    #1;
    chk("mrst_duty", 32'(duty_val), 512);
    chk("mrst_ready", 32'(s_ready), 0);
    chk("mrst_tick", 32'(frame_tick), 0);
    chk("mrst_urun", 32'(underrun), 0);
    chk("mrst_ucnt", 32'(underrun_cnt), 0);
    exp_q.delete();
    repeat (3) step();
    reset_n = 1'b1;
    n = 0;
    while (frame_tick !== 1'b1 && n < 2100) begin
      step();
      n++;
    end
    chk("mrst_first_tick", 32'(n), 1023);
    chk("mrst_tick_urun", 32'(underrun), 0);
    step();
    chk("mrst_duty_after", 32'(duty_val), 512);
    chk("mrst_ucnt_after", 32'(underrun_cnt), 0);

    chk("no_midframe_glitch", 32'(glitches), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
